// File: rtl/sw_debounce.sv
// Switch-bank synchroniser and debouncer: two-flop sync, shared sample prescaler,
// and a per-channel IDLE/PEND acceptance FSM with registered rise/fall strobes.
module sw_debounce #(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  typedef enum logic {IDLE, PEND} state_t;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] deb_q, rise_q, fall_q;
  state_t           state_q [WIDTH];
  logic [CW-1:0]    cnt_q   [WIDTH];

  // Two-flop synchroniser for the asynchronous pin inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  // Prescaler next state: wrap at TICK_DIV-1 and flag the tick for the following cycle
  always_comb begin
    pcnt_d = pcnt_q + PW'(1);
    tick_d = 1'b0;
    if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
      tick_d = 1'b1;
    end else begin
      tick_d = 1'b0;
    end
  end

  // Prescaler and tick registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  // Per-channel acceptance FSM; a match on any cycle rejects the pending change
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        case (state_q[i])
          IDLE: begin
            cnt_q[i] <= '0;
            if (sync2_q[i] != deb_q[i]) begin
              state_q[i] <= PEND;
            end else begin
              state_q[i] <= IDLE;
            end
          end
          PEND: begin
            if (sync2_q[i] == deb_q[i]) begin
              state_q[i] <= IDLE;
              cnt_q[i]   <= '0;
            end else if (tick_q) begin
              if (cnt_q[i] == CNT_LAST) begin
                deb_q[i]   <= sync2_q[i];
                rise_q[i]  <= sync2_q[i];
                fall_q[i]  <= ~sync2_q[i];
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
              end else begin
                cnt_q[i] <= cnt_q[i] + CW'(1);
              end
            end else begin
              cnt_q[i] <= cnt_q[i];
            end
          end
          default: begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign sw_debounced = deb_q;
  assign sw_rise      = rise_q;
  assign sw_fall      = fall_q;
  assign tick         = tick_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: main instance (TICK_DIV=4, STABLE_TICKS=3) and a
// fast instance (TICK_DIV=1, STABLE_TICKS=1) sharing clock and reset.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_raw, raw1;
  logic [3:0] deb, rise, fall, deb1, rise1, fall1;
  logic       tick, tick1;

  int passed = 0;
  int total  = 0;
  int rise_tot [4];
  int fall_tot [4];
  int snap_r   [4];
  int snap_f   [4];
  int tick_tot = 0;
  int snap_t;
  int viol     = 0;
  logic [3:0] prev_strobe = 4'b0000;
  int lat;

  sw_debounce #(.WIDTH(4), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw),
    .sw_debounced(deb), .sw_rise(rise), .sw_fall(fall), .tick(tick));

  sw_debounce #(.WIDTH(4), .TICK_DIV(1), .STABLE_TICKS(1)) dut1 (
    .clk(clk), .reset(reset), .sw_raw(raw1),
    .sw_debounced(deb1), .sw_rise(rise1), .sw_fall(fall1), .tick(tick1));

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_tot[i] = 0;
      fall_tot[i] = 0;
    end
  end

  // Running strobe totals and strobe-rule violations of the main instance
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      rise_tot[i] += int'(rise[i]);
      fall_tot[i] += int'(fall[i]);
    end
    tick_tot += int'(tick);
    if (((rise & fall) != 4'b0000) || (((rise | fall) & prev_strobe) != 4'b0000)) viol++;
    prev_strobe = rise | fall;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int i = 0; i < 4; i++) begin
      snap_r[i] = rise_tot[i];
      snap_f[i] = fall_tot[i];
    end
  endtask

  // Call right after driving the input; counts edges after the first sampling edge
  task automatic wait_level(input int which, input int b, input logic val, output int c);
    logic cur;
    c = 0;
    @(posedge clk);
    while (c < 40) begin
      @(posedge clk);
      #1;
      c++;
      cur = (which == 0) ? deb[b] : deb1[b];
      if (cur === val) break;
    end
  endtask

  initial begin
    reset  = 1'b1;
    sw_raw = 4'b0000;
    raw1   = 4'b0000;
    step(3);
    check("rst_deb",  32'(deb),  32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_fall", 32'(fall), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    step(2);

    // 1: clean step on bit 0
    snap();
    sw_raw = 4'b0001;
    wait_level(0, 0, 1'b1, lat);
    check("t1_latency_in_11_14", 32'(lat >= 11 && lat <= 14), 32'h1);
    check("t1_rise_at_accept", 32'(rise), 32'h1);
    check("t1_deb", 32'(deb), 32'h1);
    step(1);
    check("t1_rise_one_cycle", 32'(rise), 32'h0);
    step(3);
    check("t1_rise0_count", 32'(rise_tot[0] - snap_r[0]), 32'd1);
    check("t1_other_rises", 32'((rise_tot[1] - snap_r[1]) + (rise_tot[2] - snap_r[2]) + (rise_tot[3] - snap_r[3])), 32'd0);

    // 2: 6-cycle glitch on bit 1; also confirm tick rate of one per 4 cycles
    snap();
    snap_t = tick_tot;
    sw_raw[1] = 1'b1;
    step(6);
    sw_raw[1] = 1'b0;
    step(34);
    check("t2_deb", 32'(deb), 32'h1);
    check("t2_no_rise1", 32'(rise_tot[1] - snap_r[1]), 32'd0);
    check("t2_no_fall1", 32'(fall_tot[1] - snap_f[1]), 32'd0);
    check("t2_tick_count_40cyc", 32'(tick_tot - snap_t), 32'd10);

    // 3: bounce bit 2 every 3 cycles for 40 cycles, then settle high
    snap();
    for (int k = 0; k < 40; k++) begin
      sw_raw[2] = ((k / 3) % 2 == 0);
      step(1);
    end
    sw_raw[2] = 1'b1;
    wait_level(0, 2, 1'b1, lat);
    check("t3_latency_in_11_14", 32'(lat >= 11 && lat <= 14), 32'h1);
    step(3);
    check("t3_rise2_count", 32'(rise_tot[2] - snap_r[2]), 32'd1);
    check("t3_deb", 32'(deb), 32'h5);

    // 4: accept bit 3 high, then release it
    sw_raw[3] = 1'b1;
    wait_level(0, 3, 1'b1, lat);
    check("t4_rise_latency", 32'(lat >= 11 && lat <= 14), 32'h1);
    step(3);
    snap();
    sw_raw[3] = 1'b0;
    wait_level(0, 3, 1'b0, lat);
    check("t4_fall_latency", 32'(lat >= 11 && lat <= 14), 32'h1);
    check("t4_fall_at_accept", 32'(fall), 32'h8);
    check("t4_no_rise", 32'(rise), 32'h0);
    step(1);
    check("t4_fall_one_cycle", 32'(fall), 32'h0);
    check("t4_deb", 32'(deb), 32'h5);
    check("t4_fall3_count", 32'(fall_tot[3] - snap_f[3]), 32'd1);

    // 5: reset mid-PEND with all inputs high
    sw_raw = 4'b1111;
    step(6);
    reset = 1'b1;
    step(1);
    check("t5_rst_deb",  32'(deb),  32'h0);
    check("t5_rst_rise", 32'(rise), 32'h0);
    check("t5_rst_fall", 32'(fall), 32'h0);
    check("t5_rst_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    snap();
    wait_level(0, 0, 1'b1, lat);
    check("t5_latency", 32'(lat >= 11 && lat <= 14), 32'h1);
    check("t5_all_together", 32'(deb), 32'hF);
    check("t5_rise_all", 32'(rise), 32'hF);
    step(3);
    check("t5_one_rise_each", 32'((rise_tot[0] - snap_r[0]) + (rise_tot[1] - snap_r[1]) + (rise_tot[2] - snap_r[2]) + (rise_tot[3] - snap_r[3])), 32'd4);
    check("strobe_rules", 32'(viol), 32'd0);

    // 6: fast instance, tick every cycle and 3-cycle acceptance
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t6_tick_high_%0d", k), 32'(tick1), 32'h1);
      step(1);
    end
    raw1 = 4'b0001;
    wait_level(1, 0, 1'b1, lat);
    check("t6_rise_latency", 32'(lat), 32'd3);
    check("t6_rise_strobe", 32'(rise1), 32'h1);
    step(2);
    raw1 = 4'b0000;
    wait_level(1, 0, 1'b0, lat);
    check("t6_fall_latency", 32'(lat), 32'd3);
    check("t6_fall_strobe", 32'(fall1), 32'h1);
    check("t6_deb", 32'(deb1), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
